alu_unpack: RTL and testbench
=============================

Name: alu_unpack

Overview:
- Receive-side counterpart of the ALU operand concatenator.
- Accepts packed 2×W-bit operand words {A, B} on a valid/ready stream, buffers them in a small FIFO, and emits them as a W-bit nibble stream: A first, then B.
- Sits between the packed operand bus and the ALU's serial nibble operand loader.

Parameters:
- NIB_W, 4, width of one operand (A or B); the packed word is 2*NIB_W bits.
- DEPTH, 4, FIFO depth in packed words; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_ab  input  2*NIB_W  packed word: A in the upper half, B in the lower half.
- in_valid  input  1  in_ab is valid.
- in_ready  output  1  FIFO can accept a word.
- out_nib  output  NIB_W  current operand nibble.
- out_sel  output  1  0 = out_nib is A, 1 = out_nib is B.
- out_valid  output  1  out_nib/out_sel are valid.
- out_ready  input  1  consumer accepts out_nib.
- count  output  $clog2(DEPTH)+1  words stored, including a partially emitted head word.

Behaviour:
- Reset (async assert, sync-free deassert):
  - write pointer, read pointer, count and phase cleared to 0.
  - out_valid=0, out_nib=0, out_sel=0.
  - in_ready forced 0 while rst is high; in_ready=1 in the first cycle after release.
  - FIFO contents are not reset.
- Storage: DEPTH×(2*NIB_W) register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count carries the full/empty distinction.
- Push:
  - in_ready = (count != DEPTH) && !rst, combinational from registered count.
  - A push occurs on a clk edge where in_valid && in_ready: the word is written at the write pointer and the write pointer increments.
  - in_valid while in_ready=0 is ignored; the producer must hold the word.
- Output, combinational from registered state:
  - out_valid = (count != 0).
  - phase=0: out_nib = head[2*NIB_W-1:NIB_W], out_sel=0.
  - phase=1: out_nib = head[NIB_W-1:0], out_sel=1.
  - When empty: out_nib=0, out_sel=0.
- Handshake: a nibble transfers on a clk edge where out_valid && out_ready.
  - phase 0→1 on transfer.
  - phase 1→0 on transfer; the head word is popped and the read pointer increments.
  - No transfer: phase and head hold. out_nib/out_sel remain stable under backpressure.
- Phase state machine: two states, EMIT_A (phase=0) and EMIT_B (phase=1). Only the transitions above exist; phase never changes while out_valid=0.
- count update:
  - +1 on push only.
  - −1 on pop (EMIT_B transfer) only.
  - Unchanged on simultaneous push and pop.
  - Unchanged on an EMIT_A transfer.
- Latency and throughput:
  - A word pushed at edge N is visible on out_valid/out_nib after edge N (first cycle N+1) if the FIFO was empty.
  - One nibble per cycle; one word per 2 cycles sustained.
- Full: count=DEPTH gives in_ready=0.
  - In that cycle an EMIT_B pop can occur, but no push.
  - in_ready rises the cycle after the pop.
  - No same-cycle pass-through.
- Empty: no pop possible; a push into an empty FIFO does not produce output in the same cycle.
- Reset mid-operation: everything returns to reset values immediately; a partially emitted word is discarded, and the next word after reset starts at A.

Optional Feature:
- Macro: ALU_UNPACK_SWAP_EN.
- Defined: emission order reversed.
  - phase=0 presents the lower half (B) with out_sel=1.
  - phase=1 presents the upper half (A) with out_sel=0.
  - The pop still happens on the second transfer.
- Not defined: A-then-B order as described above.
- Ports, timing and count are identical in both builds.

Test Plan:
- Reset then push 0xA5 (NIB_W=4) with out_ready=1 → cycle 1: out_nib=0xA, sel=0; cycle 2: out_nib=0x5, sel=1; then out_valid=0, count=0.
- out_ready=0, push 0x11,0x22,0x33,0x44 → count=4, in_ready=0; a fifth word 0x55 is held and not accepted. Release out_ready → nibbles 1,1,2,2,3,3,4,4 in order; 0x55 accepted the cycle after the first pop.
- Backpressure in EMIT_B: push 0x3C, accept A, hold out_ready=0 for 3 cycles → out_nib stays 0xC with sel=1; count stays 1 until the B transfer.
- Full FIFO with continuous in_valid and out_ready=1 → one push per 2 cycles; count oscillates 4↔3; no word lost or duplicated across pointer wrap (≥10 words).
- Assert rst after A of 0x9E has transferred → out_valid=0 and count=0 immediately; next push 0x71 emits 0x7 first.
- With ALU_UNPACK_SWAP_EN defined, push 0xA5 → 0x5/sel=1, then 0xA/sel=0.

Source files
------------

// File: rtl/alu_unpack.sv
// rtl/alu_unpack.sv - packed {A,B} word FIFO emitting a W-bit operand nibble stream
// Optional macro ALU_UNPACK_SWAP_EN: emit B before A.
module alu_unpack #(
    parameter int NIB_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*NIB_W-1:0]       in_ab,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NIB_W-1:0]         out_nib,
    output logic                     out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    typedef enum logic {
        EMIT_A = 1'b0,
        EMIT_B = 1'b1
    } phase_t;

    phase_t phase;
    phase_t phase_next;

    logic [2*NIB_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [2*NIB_W-1:0] head;
    logic               push;
    logic               xfer;
    logic               pop;

    assign in_ready  = (count != FULL_CNT) && !rst;
    assign out_valid = (count != '0);
    assign head      = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (phase == EMIT_B);

    // Storage is deliberately left unreset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_ab;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            phase  <= EMIT_A;
        end else begin
            phase <= phase_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        phase_next = phase;
        out_nib    = '0;
        out_sel    = 1'b0;
        if (out_valid) begin
`ifdef ALU_UNPACK_SWAP_EN
            if (phase == EMIT_A) begin
                out_nib = head[NIB_W-1:0];
                out_sel = 1'b1;
            end else begin
                out_nib = head[2*NIB_W-1:NIB_W];
                out_sel = 1'b0;
            end
`else
            if (phase == EMIT_A) begin
                out_nib = head[2*NIB_W-1:NIB_W];
                out_sel = 1'b0;
            end else begin
                out_nib = head[NIB_W-1:0];
                out_sel = 1'b1;
            end
`endif
        end
        if (xfer) begin
            phase_next = (phase == EMIT_A) ? EMIT_B : EMIT_A;
        end
    end

endmodule

// File: tb/tb_alu_unpack.sv
// tb/tb_alu_unpack.sv - directed self-checking bench for alu_unpack
module tb_alu_unpack;

`ifdef ALU_UNPACK_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_ab;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_nib;
    logic       out_sel;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    alu_unpack #(.NIB_W(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_ab    (in_ab),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_nib  (out_nib),
        .out_sel  (out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected nibble for a word in a given phase (0 = first transfer).
    function automatic logic [3:0] nib_exp(input logic [7:0] w, input bit ph);
        bit hi;
        hi = SWAP ? ph : !ph;
        return hi ? w[7:4] : w[3:0];
    endfunction

    function automatic logic sel_exp(input bit ph);
        return SWAP ? !ph : ph;
    endfunction

    logic [7:0] words2 [5];
    logic [7:0] mq [$];
    bit         mph;
    bit         do_push;
    bit         do_xfer;
    bit         accepted;
    int         k;
    int         cyc;

    initial begin
        rst       = 1'b1;
        in_ab     = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_out_nib", out_nib, 0);
        chk("reset_out_sel", out_sel, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("release_in_ready", in_ready, 1);

        // Single word A5 with consumer always ready
        in_ab = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
        chk("t1_no_passthru", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("t1_valid0", out_valid, 1);
        chk("t1_nib0", out_nib, nib_exp(8'hA5, 0));
        chk("t1_sel0", out_sel, sel_exp(0));
        chk("t1_count0", count, 1);
        step();
        chk("t1_nib1", out_nib, nib_exp(8'hA5, 1));
        chk("t1_sel1", out_sel, sel_exp(1));
        chk("t1_count1", count, 1);
        step();
        chk("t1_empty_valid", out_valid, 0);
        chk("t1_empty_count", count, 0);
        chk("t1_empty_nib", out_nib, 0);

        // Fill to full under backpressure; fifth word must be held
        words2[0] = 8'h11; words2[1] = 8'h22; words2[2] = 8'h33;
        words2[3] = 8'h44; words2[4] = 8'h55;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_ab = words2[i]; in_valid = 1'b1;
            step();
        end
        in_ab = 8'h55;
        chk("t2_full_count", count, 4);
        chk("t2_full_ready", in_ready, 0);
        step();
        step();
        chk("t2_held_count", count, 4);
        chk("t2_held_ready", in_ready, 0);
        chk("t2_head_nib", out_nib, 4'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t2_valid", out_valid, 1);
            chk("t2_nib", out_nib, nib_exp(words2[i/2], (i % 2) == 1));
            chk("t2_sel", out_sel, sel_exp((i % 2) == 1));
            if (i < 3) chk("t2_in_ready", in_ready, (i == 2) ? 1 : 0);
            accepted = in_valid && in_ready;
            step();
            if (accepted) in_valid = 1'b0;
        end
        chk("t2_drained_valid", out_valid, 0);
        chk("t2_drained_count", count, 0);

        // Backpressure while presenting the second half
        in_ab = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_nib", out_nib, nib_exp(8'h3C, 1));
            chk("t3_hold_sel", out_sel, sel_exp(1));
            chk("t3_hold_count", count, 1);
            step();
        end
        out_ready = 1'b1;
        chk("t3_last_nib", out_nib, nib_exp(8'h3C, 1));
        step();
        chk("t3_done_count", count, 0);
        chk("t3_done_valid", out_valid, 0);
        out_ready = 1'b0;

        // Streaming through a full FIFO with a scoreboard model
        mq.delete();
        mph = 1'b0;
        k = 0;
        in_ab = 8'h03; in_valid = 1'b1;
        cyc = 0;
        while ((k < 14 || mq.size() != 0) && cyc < 300) begin
            if (cyc == 6) out_ready = 1'b1;
            chk("t4_count", count, mq.size());
            chk("t4_in_ready", in_ready, (mq.size() != 4) ? 1 : 0);
            chk("t4_valid", out_valid, (mq.size() != 0) ? 1 : 0);
            if (mq.size() != 0) begin
                chk("t4_nib", out_nib, nib_exp(mq[0], mph));
                chk("t4_sel", out_sel, sel_exp(mph));
            end
            do_push = in_valid && (mq.size() != 4);
            do_xfer = out_ready && (mq.size() != 0);
            step();
            cyc++;
            if (do_xfer) begin
                if (mph) void'(mq.pop_front());
                mph = !mph;
            end
            if (do_push) begin
                mq.push_back(in_ab);
                k++;
                if (k == 14) in_valid = 1'b0;
                else in_ab = 8'(k * 8'h1F + 8'h03);
            end
        end
        chk("t4_finished_in_budget", (cyc < 300) ? 1 : 0, 1);
        chk("t4_end_count", count, 0);

        // Reset in the middle of a word
        in_ab = 8'h9E; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t5_second_half", out_nib, nib_exp(8'h9E, 1));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_ab = 8'h71; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("t5_next_nib", out_nib, nib_exp(8'h71, 0));
        chk("t5_next_sel", out_sel, sel_exp(0));
        chk("t5_next_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
